// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter slice.
// Covers the register-file geometry, the zero word and the arbiter FSM encoding.
package rf_wb_arbiter_pkg;

    localparam int          RF_NREG   = 32;
    localparam int          RF_AW     = 5;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } wb_state_e;

    // Round-robin successor of a requester index, wrapping n-1 -> 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// Rotating-priority picker: returns a one-hot grant for the first set request
// found when searching upward from ptr. Purely combinational.
module rr_pick
    import rf_wb_arbiter_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic found_s;
    int   idx_s;

    // Scan N positions starting at ptr and grant the first active request.
    always_comb begin
        gnt     = {N{1'b0}};
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < N; k++) begin
            idx_s = (int'(ptr) + k) % N;
            if (!found_s && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Sole driver of the register-file write port: zeroes x1..x31 after reset,
// then arbitrates round-robin between the writeback sources.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 W_en,
    output logic [AW-1:0]        Rd,
    output logic [DW-1:0]        Wr_data,
    output logic                 init_done,
    output logic [2:0]           grant_id
);

    localparam int            PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] LAST_REG = AW'(RF_NREG - 1);

    if (NREQ < 2 || NREQ > 8) begin : g_nreq_illegal
        $error("rf_wb_arbiter: NREQ must be within 2..8");
    end

    wb_state_e        state_r;
    logic [AW-1:0]    init_cnt_r;
    logic [PW-1:0]    rr_ptr_r;
    logic [NREQ-1:0]  gnt_s;
    logic             xfer_s;
    logic [PW-1:0]    gidx_s;
    logic [AW-1:0]    sel_rd_s;
    logic [DW-1:0]    sel_data_s;

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_r),
        .gnt (gnt_s)
    );

    // Grants are only exposed in ARB; a reset cycle withdraws any pending grant.
    always_comb begin
        if (state_r == ST_ARB && !rst) begin
            req_ready = gnt_s;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
        xfer_s = |(req_valid & req_ready);
    end

    // Steer the granted requester's index, address and data.
    always_comb begin
        gidx_s     = {PW{1'b0}};
        sel_rd_s   = {AW{1'b0}};
        sel_data_s = {DW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_s[i]) begin
                gidx_s     = PW'(i);
                sel_rd_s   = req_rd[i*AW +: AW];
                sel_data_s = req_data[i*DW +: DW];
            end else begin
                gidx_s = gidx_s;
            end
        end
    end

    // FSM, init sweep counter, round-robin pointer and the output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_INIT;
            init_cnt_r <= AW'(1);
            rr_ptr_r   <= {PW{1'b0}};
            W_en       <= 1'b0;
            Rd         <= {AW{1'b0}};
            Wr_data    <= DW'(ZERO_WORD);
            init_done  <= 1'b0;
            grant_id   <= 3'd0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    W_en       <= 1'b1;
                    Rd         <= init_cnt_r;
                    Wr_data    <= DW'(ZERO_WORD);
                    init_cnt_r <= init_cnt_r + AW'(1);
                    if (init_cnt_r == LAST_REG) begin
                        state_r   <= ST_ARB;
                        init_done <= 1'b1;
                    end else begin
                        state_r   <= ST_INIT;
                    end
                end
                ST_ARB: begin
                    if (xfer_s) begin
                        // x0 is hardwired zero: complete the handshake but never write it.
                        W_en     <= (sel_rd_s != {AW{1'b0}});
                        Rd       <= sel_rd_s;
                        Wr_data  <= sel_data_s;
                        grant_id <= 3'(gidx_s);
                        rr_ptr_r <= PW'(wrap_inc(int'(gidx_s), NREQ));
                    end else begin
                        W_en     <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                    W_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected writes are queued when a grant is
// expected and popped/compared one cycle later against the write port.
module tb_rf_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic [2:0]    gid;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*AW-1:0] req_rd;
    logic [NREQ*DW-1:0] req_data;
    logic              W_en;
    logic [AW-1:0]     Rd;
    logic [DW-1:0]     Wr_data;
    logic              init_done;
    logic [2:0]        grant_id;

    logic [AW-1:0] rd_v   [NREQ];
    logic [DW-1:0] data_v [NREQ];
    exp_t          sb_q [$];
    int            checks;
    int            failures;

    assign req_rd   = {rd_v[2], rd_v[1], rd_v[0]};
    assign req_data = {data_v[2], data_v[1], data_v[0]};

    rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .W_en      (W_en),
        .Rd        (Rd),
        .Wr_data   (Wr_data),
        .init_done (init_done),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One ARB cycle: check the grant, queue the expected write, then check the port.
    task automatic arb_cycle(input int exp_g);
        exp_t          e;
        logic [NREQ-1:0] exp_ready;
        #1;
        exp_ready = (exp_g < 0) ? 3'b000 : NREQ'(1 << exp_g);
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        if (exp_g >= 0) begin
            e.gid  = 3'(exp_g);
            e.rd   = rd_v[exp_g];
            e.data = data_v[exp_g];
            e.wen  = (rd_v[exp_g] != 5'd0);
            sb_q.push_back(e);
        end
        tick();
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("wr_en", 64'(W_en), 64'(e.wen));
            chk("grant_id", 64'(grant_id), 64'(e.gid));
            if (e.wen) begin
                chk("wr_rd", 64'(Rd), 64'(e.rd));
                chk("wr_data", 64'(Wr_data), 64'(e.data));
            end
        end else begin
            chk("idle_wen", 64'(W_en), 64'd0);
        end
    endtask

    // Full 31-write zeroing sweep starting right after reset release.
    task automatic sweep();
        chk("init_ready_pre", 64'(req_ready), 64'd0);
        for (int k = 1; k <= 31; k++) begin
            tick();
            chk("init_wen", 64'(W_en), 64'd1);
            chk("init_rd", 64'(Rd), 64'(k));
            chk("init_data", 64'(Wr_data), 64'd0);
            chk("init_done", 64'(init_done), (k == 31) ? 64'd1 : 64'd0);
            if (k < 31) begin
                chk("init_ready", 64'(req_ready), 64'd0);
            end
        end
    endtask

    task automatic check_reset_state();
        chk("rst_wen", 64'(W_en), 64'd0);
        chk("rst_rd", 64'(Rd), 64'd0);
        chk("rst_data", 64'(Wr_data), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        req_valid = 3'b111;
        for (int i = 0; i < NREQ; i++) begin
            rd_v[i]   = 5'd0;
            data_v[i] = 32'd0;
        end
        tick();
        tick();
        check_reset_state();
        chk("rst_ready", 64'(req_ready), 64'd0);

        // Test 1: init sweep with requesters pushing; no grant may leak out.
        rst = 1'b0;
        sweep();
        req_valid = 3'b000;
        arb_cycle(-1);
        chk("idle_rd_hold", 64'(Rd), 64'd31);

        // Test 2: single requester 1.
        rd_v[1]   = 5'd5;
        data_v[1] = 32'hDEADBEEF;
        req_valid = 3'b010;
        arb_cycle(1);
        req_valid = 3'b000;
        arb_cycle(-1);

        // Test 3: bring pointer back to 0, then strict rotation with all valid.
        rd_v[0] = 5'd7;  data_v[0] = 32'hA0A0_0007;
        rd_v[1] = 5'd8;  data_v[1] = 32'hB0B0_0008;
        rd_v[2] = 5'd9;  data_v[2] = 32'hC0C0_0009;
        req_valid = 3'b100;
        arb_cycle(2);
        req_valid = 3'b111;
        for (int j = 0; j < 6; j++) begin
            arb_cycle(j % 3);
        end

        // Test 4: write to x0 completes but does not write; pointer moves to 1.
        rd_v[0]   = 5'd0;
        data_v[0] = 32'h0000_1234;
        req_valid = 3'b001;
        arb_cycle(0);
        req_valid = 3'b111;
        arb_cycle(1);
        req_valid = 3'b000;
        arb_cycle(-1);

        // Test 5: reset mid-sweep restarts from x1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("part_rd", 64'(Rd), 64'(k));
        end
        rst = 1'b1;
        tick();
        check_reset_state();
        rst = 1'b0;
        sweep();

        // Test 6: reset while requester 2 is granted drops its write.
        rd_v[2]   = 5'd12;
        data_v[2] = 32'h0000_0055;
        req_valid = 3'b100;
        arb_cycle(2);
        #1;
        chk("pre_rst_ready", 64'(req_ready), 64'b100);
        rst = 1'b1;
        #1;
        chk("rst_drop_ready", 64'(req_ready), 64'd0);
        tick();
        check_reset_state();
        sb_q.delete();
        rst = 1'b0;
        sweep();
        arb_cycle(2);
        req_valid = 3'b000;
        arb_cycle(-1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
